control_unit: RTL

Multi-cycle control FSM for the 16-bit accumulator processor. It sits directly downstream of the instruction register and consumes the opcode field of `ir_out`. It also drives the register's `ir_wr` strobe and sequences the instruction-memory, data-memory, PC and accumulator write enables through fetch, decode and execute. Instruction format: `[15:11]` opcode, `[10:0]` operand/address.

---
 rtl/cpu_pkg.sv | 50 +++++
 rtl/control_decoder.sv | 92 +++++++++
 rtl/control_unit.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 16-bit accumulator processor control path:
//   - instruction geometry (INSTRUCTION_REGISTER, OPCODE_WIDTH)
//   - opcode encodings (opcode_t), instruction format [15:11] opcode, [10:0] operand
//   - control FSM states (cu_state_t)
//   - accumulator write-source select encodings
//   - is_listed(): true for every opcode the machine defines
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int INSTRUCTION_REGISTER = 16;
    localparam int OPCODE_WIDTH         = 5;

    typedef enum logic [4:0] {
        OP_HLT  = 5'b00000,
        OP_STO  = 5'b00001,
        OP_LD   = 5'b00010,
        OP_LDI  = 5'b00011,
        OP_ADD  = 5'b00100,
        OP_ADDI = 5'b00101,
        OP_SUB  = 5'b00110,
        OP_SUBI = 5'b00111,
        OP_BEQ  = 5'b01000,
        OP_BNE  = 5'b01001,
        OP_JMP  = 5'b01110
    } opcode_t;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_HALT   = 2'd3
    } cu_state_t;

    localparam logic [1:0] ACC_SRC_ALU  = 2'b00;
    localparam logic [1:0] ACC_SRC_IMM  = 2'b01;
    localparam logic [1:0] ACC_SRC_DMEM = 2'b10;

    function automatic logic is_listed(input opcode_t op);
        logic listed;
        case (op)
            OP_HLT, OP_STO, OP_LD, OP_LDI, OP_ADD, OP_ADDI,
            OP_SUB, OP_SUBI, OP_BEQ, OP_BNE, OP_JMP: listed = 1'b1;
            default:                                 listed = 1'b0;
        endcase
        return listed;
    endfunction

endpackage

// File: rtl/control_decoder.sv
// -----------------------------------------------------------------------------
// control_decoder
// Purely combinational opcode -> EXEC-state strobe map. The FSM only forwards
// these values while it sits in EXEC, and leaves EXEC when o_done is high.
// Ports:
//   i_opcode      opcode field of the instruction register
//   i_acc_zero    accumulator == 0 (branch condition)
//   i_dmem_ready  data memory access completes this cycle
//   o_done        EXEC completes this cycle (PC update, return to FETCH)
//   o_pc_src      0 = PC+1, 1 = operand
//   o_acc_wr      accumulator load
//   o_acc_src     accumulator source select (ALU / immediate / dmem)
//   o_alu_op      0 add, 1 sub
//   o_alu_b_src   0 dmem data, 1 operand immediate
//   o_dmem_rd/wr  data memory strobes
//   o_is_hlt      opcode is HLT
//   o_is_legal    opcode is one the machine defines
// -----------------------------------------------------------------------------
module control_decoder
    import cpu_pkg::*;
(
    input  opcode_t    i_opcode,
    input  logic       i_acc_zero,
    input  logic       i_dmem_ready,
    output logic       o_done,
    output logic       o_pc_src,
    output logic       o_acc_wr,
    output logic [1:0] o_acc_src,
    output logic       o_alu_op,
    output logic       o_alu_b_src,
    output logic       o_dmem_rd,
    output logic       o_dmem_wr,
    output logic       o_is_hlt,
    output logic       o_is_legal
);

    // Opcode to EXEC strobe mapping; memory ops finish only on dmem_ready.
    always_comb begin
        o_done      = 1'b1;
        o_pc_src    = 1'b0;
        o_acc_wr    = 1'b0;
        o_acc_src   = ACC_SRC_ALU;
        o_alu_op    = 1'b0;
        o_alu_b_src = 1'b0;
        o_dmem_rd   = 1'b0;
        o_dmem_wr   = 1'b0;
        o_is_hlt    = (i_opcode == OP_HLT);
        o_is_legal  = is_listed(i_opcode);
        case (i_opcode)
            OP_LDI: begin
                o_acc_wr  = 1'b1;
                o_acc_src = ACC_SRC_IMM;
            end
            OP_ADDI, OP_SUBI: begin
                o_acc_wr    = 1'b1;
                o_alu_b_src = 1'b1;
                o_alu_op    = (i_opcode == OP_SUBI);
            end
            OP_LD: begin
                // Source select is held through the wait so the datapath mux is stable.
                o_dmem_rd = 1'b1;
                o_acc_src = ACC_SRC_DMEM;
                o_acc_wr  = i_dmem_ready;
                o_done    = i_dmem_ready;
            end
            OP_ADD, OP_SUB: begin
                o_dmem_rd = 1'b1;
                o_alu_op  = (i_opcode == OP_SUB);
                o_acc_wr  = i_dmem_ready;
                o_done    = i_dmem_ready;
            end
            OP_STO: begin
                o_dmem_wr = 1'b1;
                o_done    = i_dmem_ready;
            end
            OP_BEQ: begin
                o_pc_src = i_acc_zero;
            end
            OP_BNE: begin
                o_pc_src = ~i_acc_zero;
            end
            OP_JMP: begin
                o_pc_src = 1'b1;
            end
            default: begin
                // HLT never reaches EXEC; anything else completes as a NOP.
                o_done = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// -----------------------------------------------------------------------------
// control_unit
// Multi-cycle FETCH / DECODE / EXEC / HALT controller for the 16-bit
// accumulator processor. Consumes the opcode field of the instruction register
// and sequences imem, IR, PC, accumulator and dmem strobes.
// Build option: CU_ILLEGAL_TRAP_EN - when defined, an unlisted opcode traps to
// HALT with `illegal` set; otherwise it executes as a NOP and `illegal` is 0.
// Ports:
//   clock, cu_reset      rising-edge clock, synchronous active-high reset
//   opcode               ir_out[15:11]
//   acc_zero             accumulator == 0
//   imem_ready           instruction word valid this cycle
//   dmem_ready           data access completes this cycle
//   imem_rd, ir_wr       fetch request, instruction register load
//   pc_wr, pc_src        PC update, 0 = PC+1 / 1 = operand
//   acc_wr, acc_src      accumulator load and source select
//   alu_op, alu_b_src    0 add / 1 sub, 0 dmem / 1 immediate
//   dmem_rd, dmem_wr     data memory strobes
//   halted, illegal      FSM in HALT, illegal-opcode trap taken
// Every output is forced low while cu_reset is high.
// -----------------------------------------------------------------------------
module control_unit #(
    parameter int INSTRUCTION_REGISTER = cpu_pkg::INSTRUCTION_REGISTER,
    parameter int OPCODE_WIDTH         = cpu_pkg::OPCODE_WIDTH
) (
    input  logic                    clock,
    input  logic                    cu_reset,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic                    acc_zero,
    input  logic                    imem_ready,
    input  logic                    dmem_ready,
    output logic                    imem_rd,
    output logic                    ir_wr,
    output logic                    pc_wr,
    output logic                    pc_src,
    output logic                    acc_wr,
    output logic [1:0]              acc_src,
    output logic                    alu_op,
    output logic                    alu_b_src,
    output logic                    dmem_rd,
    output logic                    dmem_wr,
    output logic                    halted,
    output logic                    illegal
);

    import cpu_pkg::*;

    if ((OPCODE_WIDTH != $bits(opcode_t)) || (INSTRUCTION_REGISTER < OPCODE_WIDTH)) begin : g_bad_cfg
        $error("control_unit: opcode field must match opcode_t and fit in the instruction");
    end

    cu_state_t  r_state;
    cu_state_t  w_next_state;
    opcode_t    w_opcode;
    logic       w_trap;

    logic       w_dec_done;
    logic       w_dec_pc_src;
    logic       w_dec_acc_wr;
    logic [1:0] w_dec_acc_src;
    logic       w_dec_alu_op;
    logic       w_dec_alu_b_src;
    logic       w_dec_dmem_rd;
    logic       w_dec_dmem_wr;
    logic       w_dec_hlt;
    logic       w_dec_legal;

    logic       w_imem_rd;
    logic       w_ir_wr;
    logic       w_pc_wr;
    logic       w_pc_src;
    logic       w_acc_wr;
    logic [1:0] w_acc_src;
    logic       w_alu_op;
    logic       w_alu_b_src;
    logic       w_dmem_rd;
    logic       w_dmem_wr;
    logic       w_halted;

    assign w_opcode = opcode_t'(opcode);

    control_decoder u_decoder (
        .i_opcode     (w_opcode),
        .i_acc_zero   (acc_zero),
        .i_dmem_ready (dmem_ready),
        .o_done       (w_dec_done),
        .o_pc_src     (w_dec_pc_src),
        .o_acc_wr     (w_dec_acc_wr),
        .o_acc_src    (w_dec_acc_src),
        .o_alu_op     (w_dec_alu_op),
        .o_alu_b_src  (w_dec_alu_b_src),
        .o_dmem_rd    (w_dec_dmem_rd),
        .o_dmem_wr    (w_dec_dmem_wr),
        .o_is_hlt     (w_dec_hlt),
        .o_is_legal   (w_dec_legal)
    );

`ifdef CU_ILLEGAL_TRAP_EN
    logic r_illegal;

    assign w_trap = ~w_dec_legal;

    // Sticky trap flag, set when DECODE diverts an unlisted opcode to HALT.
    always_ff @(posedge clock) begin
        if (cu_reset) begin
            r_illegal <= 1'b0;
        end else if ((r_state == ST_DECODE) && w_trap && !w_dec_hlt) begin
            r_illegal <= 1'b1;
        end else begin
            r_illegal <= r_illegal;
        end
    end

    assign illegal = r_illegal & ~cu_reset;
`else
    logic w_unused_legal;

    assign w_unused_legal = w_dec_legal;
    assign w_trap         = 1'b0;
    assign illegal        = 1'b0;
`endif

    // State register.
    always_ff @(posedge clock) begin
        if (cu_reset) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and strobe generation; ir_wr and EXEC completion are Mealy on ready.
    always_comb begin
        w_next_state = r_state;
        w_imem_rd    = 1'b0;
        w_ir_wr      = 1'b0;
        w_pc_wr      = 1'b0;
        w_pc_src     = 1'b0;
        w_acc_wr     = 1'b0;
        w_acc_src    = ACC_SRC_ALU;
        w_alu_op     = 1'b0;
        w_alu_b_src  = 1'b0;
        w_dmem_rd    = 1'b0;
        w_dmem_wr    = 1'b0;
        w_halted     = 1'b0;
        case (r_state)
            ST_FETCH: begin
                w_imem_rd = 1'b1;
                if (imem_ready) begin
                    w_ir_wr      = 1'b1;
                    w_next_state = ST_DECODE;
                end else begin
                    w_next_state = ST_FETCH;
                end
            end
            ST_DECODE: begin
                if (w_dec_hlt || w_trap) begin
                    w_next_state = ST_HALT;
                end else begin
                    w_next_state = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_acc_wr    = w_dec_acc_wr;
                w_acc_src   = w_dec_acc_src;
                w_alu_op    = w_dec_alu_op;
                w_alu_b_src = w_dec_alu_b_src;
                w_dmem_rd   = w_dec_dmem_rd;
                w_dmem_wr   = w_dec_dmem_wr;
                if (w_dec_done) begin
                    w_pc_wr      = 1'b1;
                    w_pc_src     = w_dec_pc_src;
                    w_next_state = ST_FETCH;
                end else begin
                    w_next_state = ST_EXEC;
                end
            end
            ST_HALT: begin
                w_halted     = 1'b1;
                w_next_state = ST_HALT;
            end
            default: begin
                w_next_state = ST_FETCH;
            end
        endcase
    end

    // Reset overrides every output combinationally, so an access in flight is aborted.
    assign imem_rd   = w_imem_rd   & ~cu_reset;
    assign ir_wr     = w_ir_wr     & ~cu_reset;
    assign pc_wr     = w_pc_wr     & ~cu_reset;
    assign pc_src    = w_pc_src    & ~cu_reset;
    assign acc_wr    = w_acc_wr    & ~cu_reset;
    assign acc_src   = w_acc_src   & {2{~cu_reset}};
    assign alu_op    = w_alu_op    & ~cu_reset;
    assign alu_b_src = w_alu_b_src & ~cu_reset;
    assign dmem_rd   = w_dmem_rd   & ~cu_reset;
    assign dmem_wr   = w_dmem_wr   & ~cu_reset;
    assign halted    = w_halted    & ~cu_reset;

endmodule
